// File: rtl/instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Fetches two-word instructions (opcode, operand) from a ROM with one cycle of
// read latency. It holds them stable for the RAM/REG/PC consumers and issues
// one-cycle read/write strobes decoded from opcode[15:8]. It owns the program
// counter, including PC_OP jumps (select 4'h7) whose target arrives on the RAM
// read_data bus. Each instruction takes four cycles: FOP, FARG, DEC, EXEC.
//
// Ports
//   clk           in   system clock, all state on rising edge
//   reset         in   synchronous, active-high; wins over every other event
//   run           in   level; 0 stops at the next instruction boundary
//   rom_addr      out  ROM word address (pc, or pc+1 while fetching operand)
//   rom_data      in   ROM read data, valid one cycle after rom_addr
//   pc_load_data  in   RAM read_data bus, jump target for PC_OP
//   opcode        out  registered current opcode
//   operand       out  registered current operand
//   read_enable   out  one-cycle strobe in S_EXEC
//   write_enable  out  one-cycle strobe in S_EXEC
//   pc            out  address of the current instruction's opcode word
//   busy          out  1 in any state except S_IDLE / S_HALT
//   halted        out  1 in S_HALT (sticky until reset)
//   instr_count   out  retired instruction count, wraps
// -----------------------------------------------------------------------------
module instr_fetch_sequencer #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_W     = 8,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic [DATA_WIDTH-1:0] pc_load_data,
   output logic [DATA_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0] operand,
   output logic                  read_enable,
   output logic                  write_enable,
   output logic [ADDR_W-1:0]     pc,
   output logic                  busy,
   output logic                  halted,
   output logic [15:0]           instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FOP,
      S_FARG,
      S_DEC,
      S_EXEC,
      S_HALT
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_W-1:0]     pc_nxt;
   logic [DATA_WIDTH-1:0] opcode_nxt, operand_nxt;
   logic [15:0]           count_nxt;

   // Decode of opcode[15:8]: select in the upper nibble, operation below it.
   logic [7:0] op_hi;
   logic       dec_write, dec_read, dec_jump;

   assign op_hi     = opcode[DATA_WIDTH-1 -: 8];
   assign dec_jump  = (op_hi[7:4] == 4'h7);
   assign dec_write = (op_hi == 8'h41) || (op_hi == 8'h31) ||
                      (op_hi == 8'h91) || (op_hi == 8'h32);
   assign dec_read  = (op_hi == 8'h42) || (op_hi == 8'h92) ||
                      (op_hi == 8'h32) || dec_jump;

   // Only the low ADDR_W bits of the RAM bus form a jump target.
   logic unused_pc_load_hi;
   assign unused_pc_load_hi = ^pc_load_data[DATA_WIDTH-1:ADDR_W];

   assign busy   = (state != S_IDLE) && (state != S_HALT);
   assign halted = (state == S_HALT);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      opcode_nxt   = opcode;
      operand_nxt  = operand;
      count_nxt    = instr_count;
      rom_addr     = pc;
      read_enable  = 1'b0;
      write_enable = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FOP;
         end
         S_FOP: begin
            state_nxt = S_FARG;
         end
         S_FARG: begin
            // rom_data now holds ROM[pc]; request the operand word.
            opcode_nxt = rom_data;
            rom_addr   = pc + ADDR_W'(1);
            state_nxt  = S_DEC;
         end
         S_DEC: begin
            operand_nxt = rom_data;
            state_nxt   = (opcode == HALT_WORD) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            write_enable = dec_write;
            read_enable  = dec_read;
            pc_nxt       = dec_jump ? pc_load_data[ADDR_W-1:0] : pc + ADDR_W'(2);
            count_nxt    = instr_count + 16'd1;
            state_nxt    = run ? S_FOP : S_IDLE;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         opcode      <= '0;
         operand     <= '0;
         instr_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         opcode      <= opcode_nxt;
         operand     <= operand_nxt;
         instr_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_sequencer
//
// Directed bench for instr_fetch_sequencer. A table of single-instruction
// vectors is stepped through one instruction at a time from S_IDLE, followed by
// hand-written sequences for continuous run, halt, reset mid-instruction and
// dropping run mid-instruction. The ROM model has one cycle of read latency.
// -----------------------------------------------------------------------------
module tb_instr_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        run;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic [15:0] pc_load_data;
   logic [15:0] opcode;
   logic [15:0] operand;
   logic        read_enable;
   logic        write_enable;
   logic [7:0]  pc;
   logic        busy;
   logic        halted;
   logic [15:0] instr_count;

   logic [15:0] rom [256];

   int checks = 0;
   int errors = 0;

   instr_fetch_sequencer #(
      .DATA_WIDTH (16),
      .ADDR_W     (8),
      .HALT_WORD  (16'hFFFF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .pc_load_data (pc_load_data),
      .opcode       (opcode),
      .operand      (operand),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .pc           (pc),
      .busy         (busy),
      .halted       (halted),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data for rom_addr appears one cycle later.
   always_ff @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " pc"},          pc,           32'h0);
      check({tag, " rom_addr"},    rom_addr,     32'h0);
      check({tag, " opcode"},      opcode,       32'h0);
      check({tag, " operand"},     operand,      32'h0);
      check({tag, " instr_count"}, instr_count,  32'h0);
      check({tag, " strobes"},     {read_enable, write_enable}, 32'h0);
      check({tag, " busy"},        busy,         32'h0);
      check({tag, " halted"},      halted,       32'h0);
   endtask

   typedef struct {
      logic [15:0] op;
      logic [15:0] arg;
      logic [15:0] jd;       // value on pc_load_data during the instruction
      logic        exp_re;
      logic        exp_we;
      logic [7:0]  exp_pc;   // pc after the instruction retires
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [7:0]  cur_pc;
      logic [7:0]  nxt_a;
      logic [15:0] exp_count;
      int          re_cnt, we_cnt;

      vecs[0] = '{16'h4105, 16'h00AA, 16'hDEAD, 1'b0, 1'b1, 8'h02};
      vecs[1] = '{16'h7200, 16'h0010, 16'h0030, 1'b1, 1'b0, 8'h30};
      vecs[2] = '{16'h3207, 16'h5555, 16'hDEAD, 1'b1, 1'b1, 8'h32};
      vecs[3] = '{16'h1234, 16'h0001, 16'hDEAD, 1'b0, 1'b0, 8'h34};
      vecs[4] = '{16'h4205, 16'h0002, 16'hDEAD, 1'b1, 1'b0, 8'h36};
      vecs[5] = '{16'h9201, 16'h0003, 16'hDEAD, 1'b1, 1'b0, 8'h38};
      vecs[6] = '{16'h7F00, 16'h0004, 16'h12FE, 1'b1, 1'b0, 8'hFE};
      vecs[7] = '{16'h9101, 16'hBEEF, 16'hDEAD, 1'b0, 1'b1, 8'h00};
      vecs[8] = '{16'h5100, 16'h0006, 16'hDEAD, 1'b0, 1'b0, 8'h02};

      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      reset        = 1'b1;
      run          = 1'b0;
      pc_load_data = 16'h0000;
      step();
      step();
      reset = 1'b0;
      check_reset_state("reset");

      // ---- table: one instruction at a time, run pulsed from S_IDLE ----
      cur_pc    = 8'h00;
      exp_count = 16'd0;
      for (int v = 0; v < 9; v++) begin
         nxt_a        = cur_pc + 8'd1;
         rom[cur_pc]  = vecs[v].op;
         rom[nxt_a]   = vecs[v].arg;
         pc_load_data = vecs[v].jd;
         run          = 1'b1;
         step();                                  // S_FOP
         check($sformatf("v%0d fop busy", v),     busy,     32'h1);
         check($sformatf("v%0d fop rom_addr", v), rom_addr, {24'h0, cur_pc});
         run = 1'b0;
         step();                                  // S_FARG
         check($sformatf("v%0d farg rom_addr", v), rom_addr, {24'h0, nxt_a});
         step();                                  // S_DEC
         check($sformatf("v%0d dec opcode", v),  opcode, {16'h0, vecs[v].op});
         check($sformatf("v%0d dec strobes", v), {read_enable, write_enable}, 32'h0);
         step();                                  // S_EXEC
         check($sformatf("v%0d exec operand", v), operand,      {16'h0, vecs[v].arg});
         check($sformatf("v%0d exec re", v),      read_enable,  {31'h0, vecs[v].exp_re});
         check($sformatf("v%0d exec we", v),      write_enable, {31'h0, vecs[v].exp_we});
         check($sformatf("v%0d exec pc", v),      pc,           {24'h0, cur_pc});
         step();                                  // back in S_IDLE
         exp_count++;
         check($sformatf("v%0d pc after", v),       pc,          {24'h0, vecs[v].exp_pc});
         check($sformatf("v%0d rom_addr after", v), rom_addr,    {24'h0, vecs[v].exp_pc});
         check($sformatf("v%0d count", v),          instr_count, {16'h0, exp_count});
         check($sformatf("v%0d idle busy", v),      busy,        32'h0);
         check($sformatf("v%0d idle strobes", v),   {read_enable, write_enable}, 32'h0);
         cur_pc = vecs[v].exp_pc;
      end

      // ---- continuous run: 4105, jump to 0x30, then HALT ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[8'h00] = 16'h4105;  rom[8'h01] = 16'h00AA;
      rom[8'h02] = 16'h7200;  rom[8'h03] = 16'h0010;
      rom[8'h30] = 16'hFFFF;  rom[8'h31] = 16'h0000;
      pc_load_data = 16'h0030;
      run    = 1'b1;
      re_cnt = 0;
      we_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         re_cnt += int'(read_enable);
         we_cnt += int'(write_enable);
         if (c == 4) begin
            check("cont exec1 we", write_enable, 32'h1);
            check("cont exec1 operand", operand, 32'h00AA);
         end
         if (c == 5) check("cont fop2 rom_addr", rom_addr, 32'h02);
         if (c == 8) check("cont exec2 re", read_enable, 32'h1);
         if (c == 9) check("cont jump rom_addr", rom_addr, 32'h30);
      end
      check("cont we cycles", we_cnt,      32'd1);
      check("cont re cycles", re_cnt,      32'd1);
      check("halt halted",    halted,      32'h1);
      check("halt busy",      busy,        32'h0);
      check("halt count",     instr_count, 32'd2);
      check("halt pc",        pc,          32'h30);
      check("halt opcode",    opcode,      32'hFFFF);

      // run toggling must not leave S_HALT
      re_cnt = 0;
      we_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         run = c[0];
         step();
         re_cnt += int'(read_enable);
         we_cnt += int'(write_enable);
      end
      check("halt sticky halted",  halted,          32'h1);
      check("halt sticky count",   instr_count,     32'd2);
      check("halt sticky strobes", re_cnt + we_cnt, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      run   = 1'b0;
      check_reset_state("reset from halt");

      // ---- reset asserted during S_EXEC ----
      rom[8'h00] = 16'h3207;  rom[8'h01] = 16'h1111;
      run = 1'b1;
      for (int c = 0; c < 4; c++) step();
      check("rst exec strobes", {read_enable, write_enable}, 32'h3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      run   = 1'b0;
      check_reset_state("reset in exec");

      // ---- run dropped during S_FARG: instruction still completes ----
      rom[8'h00] = 16'h4105;  rom[8'h01] = 16'h00AA;
      run = 1'b1;
      step();                                     // S_FOP
      step();                                     // S_FARG
      run = 1'b0;
      step();                                     // S_DEC
      step();                                     // S_EXEC
      check("drop exec busy", busy,         32'h1);
      check("drop exec we",   write_enable, 32'h1);
      step();
      check("drop idle busy",  busy,        32'h0);
      check("drop idle count", instr_count, 32'd1);
      check("drop idle pc",    pc,          32'h02);
      step();
      check("drop stays idle", busy,        32'h0);
      check("drop pc held",    pc,          32'h02);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
